// File: rtl/ct_mmu_sysmap_arb_pkg.sv
// Shared widths, requester-id encodings and small helpers for the MMU sysmap lookup arbiter.
package ct_mmu_sysmap_arb_pkg;

    localparam int unsigned ADDR_WIDTH = 28;
    localparam int unsigned FLG_WIDTH  = 5;
    localparam int unsigned ENTRY_NUM  = 8;
    localparam int unsigned REQ_NUM    = 3;

    localparam logic [REQ_NUM-1:0] ARB_ID_PTW  = 3'b001;
    localparam logic [REQ_NUM-1:0] ARB_ID_ITLB = 3'b010;
    localparam logic [REQ_NUM-1:0] ARB_ID_DTLB = 3'b100;

    // Requester index 0..2 (PTW, ITLB, DTLB); value 3 is never used.
    typedef logic [1:0] rr_idx_t;

    function automatic rr_idx_t rr_next(input rr_idx_t idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic is_onehot(input logic [ENTRY_NUM-1:0] vec);
        return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/ct_mmu_sysmap_rr_arb.sv
// Three-way round-robin grant; the pointer names the requester with highest priority next cycle.
module ct_mmu_sysmap_rr_arb
    import ct_mmu_sysmap_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REQ_NUM-1:0] req,
    input  logic               en,
    input  logic               flush,
    output logic [REQ_NUM-1:0] gnt
);

    rr_idx_t ptr_q, ptr_d;
    rr_idx_t cand, win;
    logic    found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        win   = ptr_q;
        cand  = ptr_q;
        if (en && !flush) begin
            for (int k = 0; k < REQ_NUM; k++) begin
                if (!found && req[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
                cand = rr_next(cand);
            end
        end
        if (found) begin
            gnt[win] = 1'b1;
        end
        ptr_d = found ? rr_next(win) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ct_mmu_sysmap_arb.sv
// Arbitrates PTW/ITLB/DTLB sysmap lookups: grant, register address for lookup, register response.
module ct_mmu_sysmap_arb
    import ct_mmu_sysmap_arb_pkg::*;
(
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  ptw_arb_vld,
    input  logic [ADDR_WIDTH-1:0] ptw_arb_pa,
    input  logic                  itlb_arb_vld,
    input  logic [ADDR_WIDTH-1:0] itlb_arb_pa,
    input  logic                  dtlb_arb_vld,
    input  logic [ADDR_WIDTH-1:0] dtlb_arb_pa,
    input  logic                  mmu_arb_flush,
    output logic [REQ_NUM-1:0]    arb_gnt,
    output logic [ADDR_WIDTH-1:0] arb_sysmap_pa_y,
    input  logic [FLG_WIDTH-1:0]  sysmap_arb_flg_y,
    input  logic [ENTRY_NUM-1:0]  sysmap_arb_hit_y,
    output logic                  arb_rsp_vld,
    output logic [REQ_NUM-1:0]    arb_rsp_id,
    output logic [FLG_WIDTH-1:0]  arb_rsp_flg,
    output logic [ENTRY_NUM-1:0]  arb_rsp_hit,
    output logic                  arb_rsp_err
);

    logic [REQ_NUM-1:0]    gnt;
    logic [ADDR_WIDTH-1:0] gnt_pa;

    logic                  stg_vld_q;
    logic [REQ_NUM-1:0]    stg_id_q;
    logic [ADDR_WIDTH-1:0] stg_pa_q;

    logic                  rsp_vld_q;
    logic [REQ_NUM-1:0]    rsp_id_q;
    logic [FLG_WIDTH-1:0]  rsp_flg_q;
    logic [ENTRY_NUM-1:0]  rsp_hit_q;
    logic                  rsp_err_q;

    ct_mmu_sysmap_rr_arb u_rr_arb (
        .clk   (forever_cpuclk),
        .rst_n (cpurst_b),
        .req   ({dtlb_arb_vld, itlb_arb_vld, ptw_arb_vld}),
        .en    (1'b1),
        .flush (mmu_arb_flush),
        .gnt   (gnt)
    );

    always_comb begin
        gnt_pa = '0;
        unique case (gnt)
            ARB_ID_PTW:  gnt_pa = ptw_arb_pa;
            ARB_ID_ITLB: gnt_pa = itlb_arb_pa;
            ARB_ID_DTLB: gnt_pa = dtlb_arb_pa;
            default:     gnt_pa = '0;
        endcase
    end

    // Address only loads on a grant so the lookup input does not toggle when idle.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            stg_vld_q <= 1'b0;
            stg_id_q  <= '0;
            stg_pa_q  <= '0;
        end else begin
            stg_vld_q <= |gnt;
            if (|gnt) begin
                stg_id_q <= gnt;
                stg_pa_q <= gnt_pa;
            end
        end
    end

    // A flush kills the lookup sitting in stage 1 by suppressing its valid only.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= '0;
            rsp_flg_q <= '0;
            rsp_hit_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            rsp_vld_q <= stg_vld_q & ~mmu_arb_flush;
            if (stg_vld_q) begin
                rsp_id_q  <= stg_id_q;
                rsp_flg_q <= sysmap_arb_flg_y;
                rsp_hit_q <= sysmap_arb_hit_y;
                rsp_err_q <= ~is_onehot(sysmap_arb_hit_y);
            end
        end
    end

    assign arb_gnt         = gnt;
    assign arb_sysmap_pa_y = stg_pa_q;
    assign arb_rsp_vld     = rsp_vld_q;
    assign arb_rsp_id      = rsp_id_q;
    assign arb_rsp_flg     = rsp_flg_q;
    assign arb_rsp_hit     = rsp_hit_q;
    assign arb_rsp_err     = rsp_err_q;

endmodule

// File: doc/ct_mmu_sysmap_arb.md
Name: ct_mmu_sysmap_arb

Overview:
- Arbitrates and pipelines shared sysmap attribute lookups for three MMU requesters: PTW, ITLB refill and DTLB refill.
- Grants at most one request per cycle using round-robin priority.
- Registers the granted page address and drives it to the combinational sysmap lookup.
- Registers the returned flags and hit vector, then returns them tagged with the requester id.
- Sits between the requesters and the sysmap lookup inside the MMU top.

Parameters:
- ADDR_WIDTH, 28, page-number width (PA_WIDTH-12).
- FLG_WIDTH, 5, sysmap attribute flag width.
- ENTRY_NUM, 8, number of sysmap regions (hit vector width).
- REQ_NUM, 3, number of requesters; fixed at 3 in this version.

Ports:
- forever_cpuclk  input  1  core clock.
- cpurst_b  input  1  asynchronous active-low reset.
- ptw_arb_vld  input  1  PTW lookup request.
- ptw_arb_pa  input  ADDR_WIDTH  PTW page address.
- itlb_arb_vld  input  1  ITLB refill lookup request.
- itlb_arb_pa  input  ADDR_WIDTH  ITLB page address.
- dtlb_arb_vld  input  1  DTLB refill lookup request.
- dtlb_arb_pa  input  ADDR_WIDTH  DTLB page address.
- mmu_arb_flush  input  1  kill all in-flight lookups.
- arb_gnt  output  REQ_NUM  one-hot grant, bit0=PTW, bit1=ITLB, bit2=DTLB.
- arb_sysmap_pa_y  output  ADDR_WIDTH  registered address to sysmap lookup.
- sysmap_arb_flg_y  input  FLG_WIDTH  lookup flags (combinational from arb_sysmap_pa_y).
- sysmap_arb_hit_y  input  ENTRY_NUM  lookup hit vector.
- arb_rsp_vld  output  1  response valid.
- arb_rsp_id  output  REQ_NUM  one-hot requester id of response.
- arb_rsp_flg  output  FLG_WIDTH  registered flags.
- arb_rsp_hit  output  ENTRY_NUM  registered hit vector.
- arb_rsp_err  output  1  hit vector not one-hot (miss or multi-hit).

Behaviour:
- Reset (async, cpurst_b low):
  - stage valid, arb_rsp_vld, arb_rsp_id, arb_rsp_flg, arb_rsp_hit, arb_rsp_err and arb_sysmap_pa_y all go to 0.
  - RR pointer resets to PTW highest priority.
  - Reset mid-lookup drops the lookup silently; no response is produced.
- Grant (combinational, cycle 0):
  - arb_gnt is the one-hot selection among valid requesters, starting from the RR pointer and rotating PTW->ITLB->DTLB->PTW.
  - arb_gnt is all-zero when no requester is valid or mmu_arb_flush=1.
  - A request is consumed on the edge where vld&gnt=1.
  - A requester that is not granted holds vld and pa stable until granted.
- RR pointer:
  - Updates on a grant edge to the requester after the one granted; otherwise holds.
  - With a single continuous requester it is granted every cycle.
- Stage 1 (lookup):
  - On grant, the stage register loads the granted pa into arb_sysmap_pa_y, plus the id; stage valid=1.
  - Without a grant, stage valid=0 and arb_sysmap_pa_y holds its last value (no toggle).
- Stage 2 (response):
  - Stage 1 content registers into the response register every cycle: arb_rsp_vld = stage valid, arb_rsp_id, arb_rsp_flg = sysmap_arb_flg_y, arb_rsp_hit = sysmap_arb_hit_y.
  - arb_rsp_err = (popcount(hit) != 1).
  - flg/hit/id registers update only when stage valid; otherwise they hold.
- Latency and throughput:
  - Grant at edge N -> arb_rsp_vld high in the cycle after edge N+1, i.e. 2 cycles after the grant cycle.
  - Full throughput, one response per cycle, no back-pressure; requesters must accept the response in the cycle arb_rsp_vld is high.
- Flush:
  - While mmu_arb_flush=1, no grant is issued; stage valid and arb_rsp_vld clear on the next edge.
  - A lookup granted in the cycle before a flush never produces a response.
  - Flush and a reset edge in the same cycle: reset wins.
- Simultaneous requests: exactly one grant per cycle; the other requests wait for a later cycle.

Decomposition:
- Shared package/defines: ADDR_WIDTH, FLG_WIDTH, ENTRY_NUM, requester-id one-hot encodings (ARB_ID_PTW=3'b001, ARB_ID_ITLB=3'b010, ARB_ID_DTLB=3'b100).
- One sub-module: ct_mmu_sysmap_rr_arb, a 3-way round-robin grant with pointer register and enable/flush gating.

Test Plan:
- Single PTW request, pa=28'h0001234, lookup returns flg=5'b01111, hit=8'h04 -> arb_gnt=3'b001 in cycle 0; arb_sysmap_pa_y=28'h0001234 in cycle 1; cycle 2 arb_rsp_vld=1, id=3'b001, flg=5'b01111, hit=8'h04, err=0.
- All three valid continuously for 6 cycles after reset -> grants PTW, ITLB, DTLB, PTW, ITLB, DTLB; responses follow in the same order, 2 cycles later, back-to-back.
- Lookup returns hit=8'h00, flg=5'b10011 -> arb_rsp_err=1, flg=5'b10011; hit=8'h0C -> arb_rsp_err=1.
- DTLB granted at cycle 0, mmu_arb_flush=1 at cycle 1 with ITLB valid -> no grant at cycle 1; arb_rsp_vld stays 0 at cycles 2 and 3; ITLB granted at cycle 2 and responds at cycle 4.
- cpurst_b asserted while a lookup is in stage 1 -> all outputs 0 immediately; after release, first grant goes to PTW when PTW and DTLB are both valid.
- Idle cycles between requests -> arb_sysmap_pa_y holds its last value and arb_rsp_flg/hit/id hold while arb_rsp_vld=0.
